// File: rtl/lif_ctrl_pkg.sv
// Shared types and constants for the LIF neuron controller: FSM encoding,
// power-on neuron parameters and the spike counter ceiling.
package lif_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DEC   = 3'd1,
        S_REF   = 3'd2,
        S_ARMED = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    localparam logic [7:0] THR_DEFAULT   = 8'd100;
    localparam logic [7:0] DEC_DEFAULT   = 8'd1;
    localparam logic [7:0] REF_DEFAULT   = 8'd4;
    localparam logic [7:0] SPIKE_CNT_MAX = 8'd255;

endpackage

// File: rtl/lif_tick_prescaler.sv
// Timestep generator: a wrap counter that raises tick for one cycle each time
// it reaches the programmed period while running.
module lif_tick_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] period,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count;
    logic                  at_period;

    assign at_period = (count == period);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= at_period ? '0 : count + 1'b1;
        end
    end

    // Combinational so the pulse drops the moment run falls (stop or reset).
    assign tick = run && at_period;

endmodule

// File: rtl/lif_neuron_ctrl.sv
// Sequences the LIF neuron: byte-serial parameter load with atomic commit,
// programmable timestep enable, and a saturating spike counter per run.
module lif_neuron_ctrl
    import lif_ctrl_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    input  logic [DATA_W-1:0]     cfg_data,
    output logic                  cfg_ready,
    input  logic                  start,
    input  logic                  stop,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  spike_in,
    output logic [DATA_W-1:0]     threshold,
    output logic [DATA_W-1:0]     decay,
    output logic [DATA_W-1:0]     refractory_period,
    output logic                  neuron_enable,
    output logic [7:0]            spike_count,
    output logic                  busy
);

    state_t                state;
    logic [DATA_W-1:0]     shadow_thr;
    logic [DATA_W-1:0]     shadow_dec;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  xfer;
    logic                  run_start;
    logic                  running;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == SPIKE_CNT_MAX) ? value : value + 8'd1;
    endfunction

    assign cfg_ready = (state != S_RUN);
    assign busy      = (state == S_DEC) || (state == S_REF);
    assign running   = (state == S_RUN);
    assign xfer      = cfg_valid && cfg_ready;
    // A byte arriving in the same cycle as start takes priority; the run is dropped.
    assign run_start = (state == S_ARMED) && start && !xfer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            threshold         <= DATA_W'(THR_DEFAULT);
            decay             <= DATA_W'(DEC_DEFAULT);
            refractory_period <= DATA_W'(REF_DEFAULT);
            shadow_thr        <= '0;
            shadow_dec        <= '0;
            prescale_q        <= '0;
            spike_count       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        shadow_thr <= cfg_data;
                        state      <= S_DEC;
                    end
                end
                S_DEC: begin
                    if (xfer) begin
                        shadow_dec <= cfg_data;
                        state      <= S_REF;
                    end
                end
                S_REF: begin
                    // All three committed values change on one edge.
                    if (xfer) begin
                        threshold         <= shadow_thr;
                        decay             <= shadow_dec;
                        refractory_period <= cfg_data;
                        state             <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (xfer) begin
                        shadow_thr <= cfg_data;
                        state      <= S_DEC;
                    end else if (run_start) begin
                        prescale_q  <= prescale;
                        spike_count <= '0;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (spike_in) begin
                        spike_count <= sat_inc(spike_count);
                    end
                    if (stop) begin
                        state <= S_ARMED;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    lif_tick_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (run_start),
        .run    (running),
        .period (prescale_q),
        .tick   (neuron_enable)
    );

endmodule
